// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with retire counter and fault trapping.
// Outputs decode from the state register plus same-cycle decoder bits, alu_zero and acks; memory waits bounded by MEM_TIMEOUT.
module multicycle_sequencer #(
    parameter int                  OPCODE_W    = 8,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = 8'hFF,
    parameter int                  MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [OPCODE_W-1:0] ir_opcode,
    output logic [OPCODE_W-1:0] opcode,
    input  logic                dec_valid,
    input  logic                dec_memRead,
    input  logic                dec_memWrite,
    input  logic                dec_regWrite,
    input  logic                dec_branch,
    input  logic                alu_zero,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ack,
    output logic                rf_we,
    output logic                pc_en,
    output logic                pc_sel_branch,
    output logic [2:0]          state,
    output logic                halted,
    output logic                fault,
    output logic [15:0]         retired
);

    localparam int              TO_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    state_t              r_state;
    logic [OPCODE_W-1:0] r_opcode;
    logic [15:0]         r_retired;
    logic [TO_W-1:0]     r_wait;

    logic   w_mem_op;
    logic   w_wait_max;
    logic   w_exec_commit;
    logic   w_mem_commit;
    logic   w_commit;
    state_t w_after_commit;

    assign w_mem_op       = dec_memRead | dec_memWrite;
    assign w_wait_max     = (r_wait == TO_MAX);
    assign w_exec_commit  = (r_state == S_EXECUTE) && !w_mem_op && !dec_regWrite;
    assign w_mem_commit   = (r_state == S_MEM) && dmem_ack && !dec_regWrite;
    assign w_commit       = w_exec_commit | w_mem_commit | (r_state == S_WRITEBACK);
    // run is only consulted here, so dropping it mid-instruction never aborts the instruction
    assign w_after_commit = run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_opcode  <= '0;
            r_retired <= '0;
            r_wait    <= '0;
        end else begin
            if (w_commit) r_retired <= r_retired + 16'd1;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                        r_wait  <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_opcode <= ir_opcode;
                        r_state  <= S_DECODE;
                    end else if (w_wait_max) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_wait <= r_wait + TO_W'(1);
                    end
                end
                S_DECODE: begin
                    if (r_opcode == HALT_OPCODE)
                        r_state <= S_HALT;
                    else if (!dec_valid || (dec_memRead && dec_memWrite))
                        r_state <= S_FAULT;
                    else
                        r_state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (w_mem_op) begin
                        r_state <= S_MEM;
                        r_wait  <= '0;
                    end else if (dec_regWrite) begin
                        r_state <= S_WRITEBACK;
                    end else begin
                        r_state <= w_after_commit;
                        r_wait  <= '0;
                    end
                end
                S_MEM: begin
                    // an ack in the final allowed cycle still completes normally
                    if (dmem_ack) begin
                        if (dec_regWrite) begin
                            r_state <= S_WRITEBACK;
                        end else begin
                            r_state <= w_after_commit;
                            r_wait  <= '0;
                        end
                    end else if (w_wait_max) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_wait <= r_wait + TO_W'(1);
                    end
                end
                S_WRITEBACK: begin
                    r_state <= w_after_commit;
                    r_wait  <= '0;
                end
                S_HALT: begin
                    if (!run) r_state <= S_IDLE;
                end
                default: r_state <= S_FAULT;
            endcase
        end
    end

    assign imem_req      = (r_state == S_FETCH);
    assign dmem_req      = (r_state == S_MEM);
    assign dmem_we       = (r_state == S_MEM) && dec_memWrite;
    assign rf_we         = (r_state == S_WRITEBACK);
    assign pc_en         = w_commit;
    assign pc_sel_branch = w_exec_commit && dec_branch && alu_zero;
    assign halted        = (r_state == S_HALT);
    assign fault         = (r_state == S_FAULT);
    assign state         = r_state;
    assign opcode        = r_opcode;
    assign retired       = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: an instruction-level model expands each instruction into a per-cycle
// trace of inputs and expected outputs, which is then replayed against the DUT cycle by cycle.
module tb_multicycle_sequencer;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n, run, imem_ack, dec_valid, dec_memRead, dec_memWrite;
    logic        dec_regWrite, dec_branch, alu_zero, dmem_ack;
    logic [7:0]  ir_opcode, opcode;
    logic        imem_req, dmem_req, dmem_we, rf_we, pc_en, pc_sel_branch, halted, fault;
    logic [2:0]  state;
    logic [15:0] retired;

    multicycle_sequencer #(.OPCODE_W(8), .HALT_OPCODE(8'hFF), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_opcode(ir_opcode), .opcode(opcode),
        .dec_valid(dec_valid), .dec_memRead(dec_memRead), .dec_memWrite(dec_memWrite),
        .dec_regWrite(dec_regWrite), .dec_branch(dec_branch), .alu_zero(alu_zero),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .pc_en(pc_en), .pc_sel_branch(pc_sel_branch),
        .state(state), .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n, run, imem_ack;
        logic [7:0]  ir_op;
        logic        dv, mr, mw, rw, br, az, dack, preset;
        logic [2:0]  st;
        logic        ireq;
        logic [7:0]  op;
        logic        dreq, dwe, rfwe, pcen, psel, hlt, flt;
        logic [15:0] ret;
    } rec_t;

    rec_t        trace[$];
    rec_t        r;
    logic [7:0]  m_opcode;
    logic [15:0] m_retired;
    logic        m_at_idle;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // opcode table of the external decoder: {valid, memRead, memWrite, regWrite, branch}
    function automatic logic [4:0] dec_of(input logic [7:0] op);
        case (op)
            8'h01:   return 5'b10010;
            8'h10:   return 5'b11010;
            8'h20:   return 5'b10100;
            8'h30:   return 5'b10001;
            8'h00:   return 5'b10000;
            8'h40:   return 5'b11100;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic begin_cyc(input logic [2:0] st);
        r          = '0;
        r.rst_n    = 1'b1;
        r.run      = 1'($urandom_range(0, 1));
        r.imem_ack = 1'($urandom_range(0, 1));
        r.ir_op    = 8'($urandom);
        {r.dv, r.mr, r.mw, r.rw, r.br} = dec_of(m_opcode);
        r.az       = 1'($urandom_range(0, 1));
        r.dack     = 1'($urandom_range(0, 1));
        r.st       = st;
        r.op       = m_opcode;
        r.ret      = m_retired;
        r.hlt      = (st == 3'd6);
        r.flt      = (st == 3'd7);
    endtask

    task automatic end_cyc();
        trace.push_back(r);
    endtask

    task automatic do_reset(input int n);
        m_opcode  = 8'h00;
        m_retired = 16'h0000;
        for (int i = 0; i < n; i++) begin
            begin_cyc(3'd0);
            r.rst_n = 1'b0;
            end_cyc();
        end
        m_at_idle = 1'b1;
    endtask

    task automatic fault_tail();
        int n;
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) begin
            begin_cyc(3'd7);
            end_cyc();
        end
        do_reset(1);
    endtask

    task automatic commit_cyc(input logic run_end);
        r.pcen = 1'b1;
        r.run  = run_end;
        end_cyc();
        m_retired = m_retired + 16'd1;
        m_at_idle = !run_end;
    endtask

    task automatic gen_instr(input logic [7:0] op, input int di, input int dd,
                             input logic az, input logic run_end, output int ncyc);
        int   fstart, n;
        logic got, dv, mr, mw, rw, br;
        ncyc = -1;
        if (m_at_idle) begin
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                begin_cyc(3'd0);
                r.run = 1'b0;
                end_cyc();
            end
            begin_cyc(3'd0);
            r.run = 1'b1;
            end_cyc();
        end
        fstart = trace.size();
        got = 1'b0;
        for (int k = 0; k <= TO && !got; k++) begin
            begin_cyc(3'd1);
            r.ireq     = 1'b1;
            r.imem_ack = (k == di);
            if (k == di) r.ir_op = op;
            end_cyc();
            got = (k == di);
        end
        if (!got) begin
            fault_tail();
            return;
        end
        m_opcode = op;
        {dv, mr, mw, rw, br} = dec_of(op);
        begin_cyc(3'd2);
        end_cyc();
        if (op == 8'hFF) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                begin_cyc(3'd6);
                r.run = 1'b1;
                end_cyc();
            end
            begin_cyc(3'd6);
            r.run = 1'b0;
            end_cyc();
            m_at_idle = 1'b1;
            return;
        end
        if (!dv || (mr && mw)) begin
            fault_tail();
            return;
        end
        begin_cyc(3'd3);
        r.az = az;
        if (!mr && !mw && !rw) begin
            r.psel = br & az;
            commit_cyc(run_end);
            ncyc = trace.size() - fstart;
            return;
        end
        end_cyc();
        if (mr || mw) begin
            got = 1'b0;
            for (int k = 0; k <= TO && !got; k++) begin
                begin_cyc(3'd4);
                r.dreq = 1'b1;
                r.dwe  = mw;
                r.dack = (k == dd);
                got    = (k == dd);
                if (got && !rw) commit_cyc(run_end);
                else end_cyc();
            end
            if (!got) begin
                fault_tail();
                return;
            end
            if (!rw) begin
                ncyc = trace.size() - fstart;
                return;
            end
        end
        begin_cyc(3'd5);
        r.rfwe = 1'b1;
        commit_cyc(run_end);
        ncyc = trace.size() - fstart;
    endtask

    task automatic gen_random(input int count);
        int         sel, nc, di, dd;
        logic [7:0] op;
        for (int i = 0; i < count; i++) begin
            sel = $urandom_range(0, 99);
            if      (sel < 25) op = 8'h01;
            else if (sel < 45) op = 8'h10;
            else if (sel < 60) op = 8'h20;
            else if (sel < 75) op = 8'h30;
            else if (sel < 86) op = 8'h00;
            else if (sel < 90) op = 8'hFF;
            else if (sel < 94) op = 8'h40;
            else               op = 8'h55;
            di = ($urandom_range(0, 14) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 2);
            dd = ($urandom_range(0, 14) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
            gen_instr(op, di, dd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), nc);
        end
    endtask

    initial begin
        int   nc;
        logic [63:0] act, exp;
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; ir_opcode = 8'h00;
        dec_valid = 1'b0; dec_memRead = 1'b0; dec_memWrite = 1'b0;
        dec_regWrite = 1'b0; dec_branch = 1'b0; alu_zero = 1'b0; dmem_ack = 1'b0;

        do_reset(2);
        gen_instr(8'h01, 0, 0, 1'b0, 1'b1, nc);  check("lat_alu", 64'(nc), 64'd4);
        gen_instr(8'h10, 0, 3, 1'b0, 1'b1, nc);  check("lat_load_wait3", 64'(nc), 64'd8);
        gen_instr(8'h20, 0, 3, 1'b0, 1'b1, nc);  check("lat_store_wait3", 64'(nc), 64'd7);
        gen_instr(8'h10, 0, 0, 1'b0, 1'b1, nc);  check("lat_load", 64'(nc), 64'd5);
        gen_instr(8'h20, 0, 0, 1'b0, 1'b0, nc);  check("lat_store", 64'(nc), 64'd4);
        gen_instr(8'h30, 0, 0, 1'b1, 1'b1, nc);  check("lat_branch_taken", 64'(nc), 64'd3);
        gen_instr(8'h30, 0, 0, 1'b0, 1'b1, nc);  check("lat_branch_not", 64'(nc), 64'd3);
        gen_instr(8'h00, 1, 0, 1'b1, 1'b1, nc);  check("lat_nop_fwait1", 64'(nc), 64'd4);
        gen_instr(8'hFF, 0, 0, 1'b0, 1'b1, nc);  check("halt_retired", 64'(m_retired), 64'd8);
        begin_cyc(3'd0);
        r.run = 1'b0; r.preset = 1'b1; r.ret = 16'hFFFF; m_retired = 16'hFFFF;
        end_cyc();
        gen_instr(8'h01, 0, 0, 1'b0, 1'b1, nc);  check("wrap_model", 64'(m_retired), 64'd0);
        gen_instr(8'h01, 15, 0, 1'b0, 1'b1, nc); check("lat_fetch_last_ack", 64'(nc), 64'd19);
        gen_instr(8'h10, 0, 15, 1'b0, 1'b1, nc); check("lat_mem_last_ack", 64'(nc), 64'd20);
        gen_instr(8'h01, 16, 0, 1'b0, 1'b1, nc);
        gen_instr(8'h10, 0, 16, 1'b0, 1'b1, nc);
        gen_instr(8'h55, 0, 0, 1'b0, 1'b1, nc);
        gen_instr(8'h40, 0, 0, 1'b0, 1'b1, nc);
        gen_random(250);
        do_reset(2);

        for (int i = 0; i < trace.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n        = trace[i].rst_n;
            run          = trace[i].run;
            imem_ack     = trace[i].imem_ack;
            ir_opcode    = trace[i].ir_op;
            dec_valid    = trace[i].dv;
            dec_memRead  = trace[i].mr;
            dec_memWrite = trace[i].mw;
            dec_regWrite = trace[i].rw;
            dec_branch   = trace[i].br;
            alu_zero     = trace[i].az;
            dmem_ack     = trace[i].dack;
            if (trace[i].preset) force dut.r_retired = 16'hFFFF;
            @(negedge clk);
            act = 64'({state, imem_req, opcode, dmem_req, dmem_we, rf_we, pc_en,
                       pc_sel_branch, halted, fault, retired});
            exp = 64'({trace[i].st, trace[i].ireq, trace[i].op, trace[i].dreq, trace[i].dwe,
                       trace[i].rfwe, trace[i].pcen, trace[i].psel, trace[i].hlt,
                       trace[i].flt, trace[i].ret});
            check($sformatf("cycle %0d {st,ireq,op,dreq,dwe,rfwe,pcen,psel,hlt,flt,ret}", i), act, exp);
            if (trace[i].preset) release dut.r_retired;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
